// File: rtl/uart_alu_pkg.sv
// Shared constants and types for the UART ALU datapath: status codes, opcodes,
// and the response header layout.
package uart_alu_pkg;

  localparam int unsigned RESP_HDR_BYTES = 4;

  localparam logic [7:0] STATUS_OK    = 8'h00;
  localparam logic [7:0] STATUS_DIV0  = 8'h01;
  localparam logic [7:0] STATUS_BADOP = 8'h02;

  // Opcodes shared with the receive-side command parser
  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h02;
  localparam logic [7:0] OP_MUL = 8'h03;
  localparam logic [7:0] OP_DIV = 8'h04;

  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] status;
  } resp_hdr_t;

endpackage

// File: rtl/alu_resp_packer.sv
// Transmit-side framer: captures one ALU result and streams it out as
// opcode, status, 16-bit length, then little-endian result bytes.
module alu_resp_packer
  import uart_alu_pkg::*;
#(
  parameter int unsigned datawidth_p    = 8,
  parameter int unsigned result_width_p = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [result_width_p-1:0] result_i,
  input  logic [7:0]                opcode_i,
  input  logic [7:0]                status_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  output logic [datawidth_p-1:0]    m_axis_tdata_o,
  output logic                      m_axis_tvalid_o,
  input  logic                      m_axis_tready_i,
  output logic                      busy_o
);

  localparam int unsigned RESULT_BYTES = result_width_p / 8;
  localparam int unsigned PKT_BYTES    = RESP_HDR_BYTES + RESULT_BYTES;
  localparam int unsigned IDX_W        = $clog2(PKT_BYTES);
  localparam logic [15:0] PKT_LEN      = 16'(PKT_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_BYTES - 1);

  if (datawidth_p != 8) begin : g_bad_datawidth
    $error("alu_resp_packer: datawidth_p must be 8");
  end
  if ((result_width_p % 8) != 0 || result_width_p < 8 || result_width_p > 64) begin : g_bad_result_width
    $error("alu_resp_packer: result_width_p must be a multiple of 8 in 8..64");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  resp_hdr_t                hdr_q, hdr_d;
  logic [result_width_p-1:0] result_q, result_d;
  logic [datawidth_p-1:0]   tdata_q, tdata_d;
  logic                     tvalid_q, tvalid_d;
  logic                     ready_q, ready_d;
  logic                     busy_q, busy_d;

  logic [IDX_W-1:0]         idx_inc;
  logic [7:0]               pkt_bytes [PKT_BYTES];

  // Byte view of the captured packet, selected by index when advancing
  always_comb begin
    pkt_bytes[0] = hdr_q.opcode;
    pkt_bytes[1] = hdr_q.status;
    pkt_bytes[2] = PKT_LEN[7:0];
    pkt_bytes[3] = PKT_LEN[15:8];
    for (int unsigned i = 0; i < RESULT_BYTES; i++) begin
      pkt_bytes[RESP_HDR_BYTES + i] = result_q[8*i +: 8];
    end
  end

  assign idx_inc = idx_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    hdr_d    = hdr_q;
    result_d = result_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    ready_d  = ready_q;
    busy_d   = busy_q;

    unique case (state_q)
      ST_IDLE: begin
        if (valid_i && ready_q) begin
          hdr_d    = '{opcode: opcode_i, status: status_i};
          result_d = result_i;
          // First byte comes straight from the inputs; holding regs load this edge
          tdata_d  = datawidth_p'(opcode_i);
          tvalid_d = 1'b1;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
          idx_d    = '0;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tvalid_q && m_axis_tready_i) begin
          if (idx_q == LAST_IDX) begin
            tvalid_d = 1'b0;
            busy_d   = 1'b0;
            ready_d  = 1'b1;
            idx_d    = '0;
            state_d  = ST_IDLE;
          end else begin
            idx_d   = idx_inc;
            tdata_d = datawidth_p'(pkt_bytes[idx_inc]);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      hdr_q    <= '0;
      result_q <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      hdr_q    <= hdr_d;
      result_q <= result_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign ready_o         = ready_q;
  assign busy_o          = busy_q;
  assign m_axis_tdata_o  = tdata_q;
  assign m_axis_tvalid_o = tvalid_q;

endmodule

// File: tb/tb_alu_resp_packer.sv
// Randomised self-checking bench for alu_resp_packer: 32-bit and 16-bit
// result instances checked against a byte-list packet model.
module tb_alu_resp_packer;
  import uart_alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [31:0] res32;
  logic [7:0]  op32, st32, td32;
  logic        v32, rdy32, tv32, trdy32, busy32;

  logic [15:0] res16;
  logic [7:0]  op16, st16, td16;
  logic        v16, rdy16, tv16, trdy16, busy16;

  alu_resp_packer #(.datawidth_p(8), .result_width_p(32)) dut32 (
    .clk_i(clk), .rst_i(rst), .result_i(res32), .opcode_i(op32), .status_i(st32),
    .valid_i(v32), .ready_o(rdy32), .m_axis_tdata_o(td32), .m_axis_tvalid_o(tv32),
    .m_axis_tready_i(trdy32), .busy_o(busy32)
  );

  alu_resp_packer #(.datawidth_p(8), .result_width_p(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .result_i(res16), .opcode_i(op16), .status_i(st16),
    .valid_i(v16), .ready_o(rdy16), .m_axis_tdata_o(td16), .m_axis_tvalid_o(tv16),
    .m_axis_tready_i(trdy16), .busy_o(busy16)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];

  // Reference packet: header, 16-bit total length, result LSB first
  function automatic void model_pkt(input logic [7:0] op, input logic [7:0] st,
                                    input logic [63:0] res, input int rbytes);
    int n;
    n = 4 + rbytes;
    exp_q.delete();
    exp_q.push_back(op);
    exp_q.push_back(st);
    exp_q.push_back(8'(n % 256));
    exp_q.push_back(8'(n / 256));
    for (int i = 0; i < rbytes; i++) exp_q.push_back(8'((res >> (8 * i)) & 64'hFF));
  endfunction

  // Present a command at a falling edge; returns one falling edge after capture
  task automatic send_cmd(input bit sel16, input logic [7:0] op, input logic [7:0] st,
                          input logic [31:0] res);
    if (sel16) begin
      op16 = op; st16 = st; res16 = res[15:0]; v16 = 1'b1;
    end else begin
      op32 = op; st32 = st; res32 = res; v32 = 1'b1;
    end
    @(negedge clk);
  endtask

  // Sink: drives tready each cycle, logs accepted bytes and stall-stability violations
  task automatic collect(input bit sel16, input bit rand_rdy, input int want, input int budget,
                         output int cycles, output int unstable, output int ready_hi,
                         output bit timed_out);
    logic [7:0] prev, td;
    logic       tv, rd, r;
    bit         stall;
    stall = 1'b0; prev = '0;
    cycles = 0; unstable = 0; ready_hi = 0;
    got_q.delete();
    while (got_q.size() < want && cycles < budget) begin
      r = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sel16) trdy16 = r; else trdy32 = r;
      tv = sel16 ? tv16 : tv32;
      td = sel16 ? td16 : td32;
      rd = sel16 ? rdy16 : rdy32;
      if (stall && (!tv || td !== prev)) unstable++;
      if (rd) ready_hi++;
      if (tv && r) got_q.push_back(td);
      stall = tv && !r;
      prev  = td;
      cycles++;
      @(negedge clk);
    end
    timed_out = (got_q.size() < want);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (tv32 !== 1'b0 || td32 !== 8'h00) begin n_fail++;
      $display("FAIL reset32_stream got tvalid=%b tdata=%02h exp 0/00", tv32, td32); end
    n_cmp++; if (rdy32 !== 1'b1 || busy32 !== 1'b0) begin n_fail++;
      $display("FAIL reset32_ctrl got ready=%b busy=%b exp 1/0", rdy32, busy32); end
    n_cmp++; if (tv16 !== 1'b0 || rdy16 !== 1'b1 || busy16 !== 1'b0) begin n_fail++;
      $display("FAIL reset16 got tvalid=%b ready=%b busy=%b exp 0/1/0", tv16, rdy16, busy16); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc, unst, rhi; bit to;
    send_cmd(1'b0, OP_ADD, STATUS_OK, 32'h12345678);
    n_cmp++; if (tv32 !== 1'b1 || td32 !== 8'h01 || busy32 !== 1'b1 || rdy32 !== 1'b0) begin n_fail++;
      $display("FAIL basic_first got tv=%b td=%02h busy=%b rdy=%b exp 1/01/1/0", tv32, td32, busy32, rdy32); end
    v32 = 1'b0;
    collect(1'b0, 1'b0, 8, 50, cyc, unst, rhi, to);
    model_pkt(OP_ADD, STATUS_OK, 64'h12345678, 4);
    n_cmp++; if (to || cyc != 8) begin n_fail++;
      $display("FAIL basic_timing got cycles=%0d timeout=%0b exp 8/0", cyc, to); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++;
        $display("FAIL basic_byte%0d got %02h exp %02h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (rdy32 !== 1'b1 || tv32 !== 1'b0 || busy32 !== 1'b0) begin n_fail++;
      $display("FAIL basic_done got rdy=%b tv=%b busy=%b exp 1/0/0", rdy32, tv32, busy32); end
  endtask

  task automatic test_backpressure();
    int cyc, unst, rhi; bit to;
    send_cmd(1'b0, OP_ADD, STATUS_OK, 32'h12345678);
    v32 = 1'b0;
    collect(1'b0, 1'b1, 8, 300, cyc, unst, rhi, to);
    model_pkt(OP_ADD, STATUS_OK, 64'h12345678, 4);
    n_cmp++; if (to || got_q.size() != 8) begin n_fail++;
      $display("FAIL bp_count got %0d bytes timeout=%0b exp 8/0", got_q.size(), to); end
    n_cmp++; if (unst != 0) begin n_fail++;
      $display("FAIL bp_stable got %0d unstable stalls exp 0", unst); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++;
        $display("FAIL bp_byte%0d got %02h exp %02h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (tv32 !== 1'b0 || rdy32 !== 1'b1) begin n_fail++;
      $display("FAIL bp_done got tv=%b rdy=%b exp 0/1", tv32, rdy32); end
  endtask

  task automatic test_isolation();
    int cyc, unst, rhi; bit to;
    send_cmd(1'b0, OP_MUL, STATUS_OK, 32'h12345678);
    res32 = 32'hDEADBEEF; op32 = OP_SUB; st32 = STATUS_BADOP;
    collect(1'b0, 1'b1, 8, 300, cyc, unst, rhi, to);
    model_pkt(OP_MUL, STATUS_OK, 64'h12345678, 4);
    n_cmp++; if (to || rhi != 0) begin n_fail++;
      $display("FAIL iso_ready got ready_high_cycles=%0d timeout=%0b exp 0/0", rhi, to); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++;
        $display("FAIL iso_a_byte%0d got %02h exp %02h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (rdy32 !== 1'b1) begin n_fail++;
      $display("FAIL iso_ready_back got %b exp 1", rdy32); end
    @(negedge clk);
    v32 = 1'b0;
    collect(1'b0, 1'b0, 8, 50, cyc, unst, rhi, to);
    model_pkt(OP_SUB, STATUS_BADOP, 64'hDEADBEEF, 4);
    n_cmp++; if (to || got_q.size() != 8) begin n_fail++;
      $display("FAIL iso_b_count got %0d timeout=%0b exp 8/0", got_q.size(), to); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++;
        $display("FAIL iso_b_byte%0d got %02h exp %02h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc, unst, rhi; bit to;
    logic [31:0] r1, r2;
    r1 = $urandom; r2 = $urandom;
    send_cmd(1'b0, OP_DIV, STATUS_DIV0, r1);
    op32 = OP_SUB; st32 = STATUS_OK; res32 = r2;
    collect(1'b0, 1'b0, 8, 50, cyc, unst, rhi, to);
    model_pkt(OP_DIV, STATUS_DIV0, 64'(r1), 4);
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++;
        $display("FAIL b2b_p1_byte%0d got %02h exp %02h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (tv32 !== 1'b0) begin n_fail++;
      $display("FAIL b2b_gap got tvalid=%b exp 0", tv32); end
    @(negedge clk);
    n_cmp++; if (tv32 !== 1'b1 || td32 !== OP_SUB) begin n_fail++;
      $display("FAIL b2b_p2_start got tv=%b td=%02h exp 1/%02h", tv32, td32, OP_SUB); end
    v32 = 1'b0;
    collect(1'b0, 1'b0, 8, 50, cyc, unst, rhi, to);
    model_pkt(OP_SUB, STATUS_OK, 64'(r2), 4);
    n_cmp++; if (to || got_q.size() != 8) begin n_fail++;
      $display("FAIL b2b_p2_count got %0d timeout=%0b exp 8/0", got_q.size(), to); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++;
        $display("FAIL b2b_p2_byte%0d got %02h exp %02h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_packet();
    int cyc, unst, rhi; bit to;
    logic [31:0] r;
    r = $urandom;
    send_cmd(1'b0, OP_MUL, STATUS_OK, 32'hCAFEF00D);
    v32 = 1'b0;
    collect(1'b0, 1'b0, 4, 50, cyc, unst, rhi, to);
    n_cmp++; if (tv32 !== 1'b1 || td32 !== 8'h0D) begin n_fail++;
      $display("FAIL rstmid_pre got tv=%b td=%02h exp 1/0d", tv32, td32); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (tv32 !== 1'b0 || rdy32 !== 1'b1 || busy32 !== 1'b0 || td32 !== 8'h00) begin n_fail++;
      $display("FAIL rstmid_state got tv=%b rdy=%b busy=%b td=%02h exp 0/1/0/00", tv32, rdy32, busy32, td32); end
    rst = 1'b1; trdy32 = 1'b1;
    @(negedge clk);
    n_cmp++; if (tv32 !== 1'b0) begin n_fail++;
      $display("FAIL rstmid_stale got tvalid=%b exp 0", tv32); end
    send_cmd(1'b0, OP_ADD, STATUS_BADOP, r);
    v32 = 1'b0;
    collect(1'b0, 1'b1, 8, 300, cyc, unst, rhi, to);
    model_pkt(OP_ADD, STATUS_BADOP, 64'(r), 4);
    n_cmp++; if (to || got_q.size() != 8) begin n_fail++;
      $display("FAIL rstmid_count got %0d timeout=%0b exp 8/0", got_q.size(), to); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++;
        $display("FAIL rstmid_byte%0d got %02h exp %02h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    int cyc, unst, rhi; bit to;
    logic [7:0] op, st;
    logic [31:0] r;
    for (int p = 0; p < 10; p++) begin
      op = 8'($urandom); st = 8'($urandom_range(0, 2)); r = $urandom;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_cmd(1'b0, op, st, r);
      v32 = 1'b0;
      collect(1'b0, 1'b1, 8, 300, cyc, unst, rhi, to);
      model_pkt(op, st, 64'(r), 4);
      n_cmp++; if (to || unst != 0 || got_q.size() != 8) begin n_fail++;
        $display("FAIL rand%0d_flow got bytes=%0d unstable=%0d timeout=%0b exp 8/0/0", p, got_q.size(), unst, to); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++;
          $display("FAIL rand%0d_byte%0d got %02h exp %02h", p, i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_width16();
    int cyc, unst, rhi; bit to;
    logic [7:0] want [6];
    want = '{OP_MUL, STATUS_BADOP, 8'h06, 8'h00, 8'hC3, 8'hA5};
    send_cmd(1'b1, OP_MUL, STATUS_BADOP, 32'h0000A5C3);
    v16 = 1'b0;
    collect(1'b1, 1'b0, 6, 50, cyc, unst, rhi, to);
    n_cmp++; if (to || cyc != 6) begin n_fail++;
      $display("FAIL w16_timing got cycles=%0d timeout=%0b exp 6/0", cyc, to); end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== want[i]) begin n_fail++;
        $display("FAIL w16_byte%0d got %02h exp %02h", i, got_q[i], want[i]); end
    end
    send_cmd(1'b1, 8'h5A, STATUS_OK, 32'($urandom));
    v16 = 1'b0;
    model_pkt(8'h5A, STATUS_OK, 64'(res16), 2);
    collect(1'b1, 1'b1, 6, 300, cyc, unst, rhi, to);
    n_cmp++; if (to || unst != 0 || got_q.size() != 6) begin n_fail++;
      $display("FAIL w16_rand_flow got bytes=%0d unstable=%0d timeout=%0b exp 6/0/0", got_q.size(), unst, to); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++;
        $display("FAIL w16_rand_byte%0d got %02h exp %02h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    rst = 1'b0;
    res32 = '0; op32 = '0; st32 = '0; v32 = 1'b0; trdy32 = 1'b0;
    res16 = '0; op16 = '0; st16 = '0; v16 = 1'b0; trdy16 = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_isolation();
    test_back_to_back();
    test_reset_mid_packet();
    test_random();
    test_width16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_resp_packer.md
Name: alu_resp_packer

Overview:
- Transmit-side framer for the UART ALU.
- Accepts one ALU result word with its opcode and status, then serialises it into a fixed-format response packet.
- Emits the packet as a byte-wide AXI-Stream into uart_tx (tx_inst).
- Mirror of the command parser on the receive path: it builds the packets the PC-side host decodes.

Parameters:
- datawidth_p, 8, stream byte width; must be 8 (elaboration-time check).
- result_width_p, 32, ALU result width; must be a multiple of 8, range 8..64 (elaboration-time check).

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  synchronous, active-low reset (asserted when 0)
- result_i  input  result_width_p  ALU result word
- opcode_i  input  8  opcode of the command that produced the result
- status_i  input  8  status code (uart_alu_pkg::STATUS_*)
- valid_i  input  1  result/opcode/status valid
- ready_o  output  1  packer can accept a result
- m_axis_tdata_o  output  datawidth_p  stream byte to uart_tx
- m_axis_tvalid_o  output  1  stream byte valid
- m_axis_tready_i  input  1  uart_tx ready
- busy_o  output  1  packet in progress

Behaviour:
- Packet format, N = 4 + result_width_p/8 bytes:
  - B0 = opcode
  - B1 = status
  - B2 = N[7:0]
  - B3 = N[15:8]
  - B4..B(N-1) = result bytes, little-endian (B4 = result[7:0]).
- All outputs are registered.
- Reset values (rst_i == 0 at a clock edge): m_axis_tvalid_o=0, m_axis_tdata_o=0, ready_o=1, busy_o=0, byte index=0, state=IDLE.
- Reset mid-packet: the packet is discarded. No further bytes of it are emitted after reset releases; the next packet starts from B0.
- States:
  - IDLE: ready_o=1, busy_o=0, tvalid=0.
    - valid_i && ready_o -> capture opcode/status/result into holding registers; go to SEND.
    - In the same edge: tdata<=B0, tvalid<=1, ready_o<=0, busy_o<=1, idx<=0.
    - Capture-to-first-tvalid latency: 1 cycle.
  - SEND: tvalid=1; tdata stays stable until the handshake (tvalid && tready_i).
    - On handshake with idx < N-1: idx<=idx+1, tdata<=byte[idx+1], tvalid stays 1. This gives back-to-back bytes, one per cycle, while tready_i is held high.
    - On handshake with idx == N-1: tvalid<=0, busy_o<=0, ready_o<=1, go to IDLE.
- Inputs are ignored while ready_o=0. result_i, opcode_i and status_i may change freely after capture without affecting the packet in flight.
- A new result can be accepted one cycle after the last byte's handshake. Minimum packet period is N+1 cycles.
- tvalid never deasserts without a handshake (AXI-Stream rule). tready_i toggling arbitrarily must not drop, duplicate or reorder bytes.
- The byte index counter is ceil(log2(N)) bits wide and never wraps past N-1.
- Length field is 16-bit unsigned, constant for a given result_width_p.

Decomposition:
- uart_alu_pkg holds:
  - status codes: STATUS_OK=8'h00, STATUS_DIV0=8'h01, STATUS_BADOP=8'h02
  - RESP_HDR_BYTES=4
  - opcode constants shared with the command parser.
- Single flat module; the byte mux is an indexed select inside it. No sub-module.

Test Plan:
- Basic packet: reset low 3 cycles, release; valid_i=1 with opcode=8'h01, status=0, result=32'h12345678; tready_i held 1 -> bytes 01 00 08 00 78 56 34 12 on consecutive cycles starting 1 cycle after capture; ready_o returns to 1 after the 8th handshake.
- Backpressure: same packet, tready_i random (~50% duty) -> identical byte sequence; tdata stable every cycle tvalid=1 && tready_i=0; no duplicates.
- Input isolation: during SEND, drive valid_i=1 and change result_i to 32'hDEADBEEF -> in-flight packet unchanged; ready_o stays 0; second packet is sent only if valid_i is still high when ready_o returns, with bytes EF BE AD DE in its payload.
- Back-to-back: two results queued with valid_i held high -> packets separated by exactly one idle cycle (tvalid=0), with correct opcode/status per packet (e.g. 8'h04/STATUS_DIV0, then 8'h02/STATUS_OK).
- Reset mid-packet: assert rst_i=0 after B3 handshake -> next cycle tvalid=0, ready_o=1; after release a new command emits from B0, with no stale bytes.
- Parameter sweep: result_width_p=16 with result=16'hA5C3 -> bytes op st 06 00 C3 A5.
